// File: rtl/instr_mem_pl.sv
// instr_mem_pl: boot ROM + loader-writable RAM behind one fetch port; INSTR_MEM_ROM_EN enables the `rom` backing.
// Latency READ_LAT cycles from grant; loader writes take priority and deny RAM-region grants that cycle.

`ifdef INSTR_MEM_ROM_EN
module rom #(
  parameter int AW = 11
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);
  // Boot image stand-in: recognisable tag plus word index.
  assign rdata_o = {16'hB007, 16'(addr_i)};
endmodule
`endif

module instr_mem_pl #(
  parameter int          ADDR_W    = 14,
  parameter int unsigned RAM_WORDS = 2048,
  parameter int          READ_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-2:0] ld_addr_i,
  input  logic [3:0]        ld_be_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ld_gnt_o
);
  localparam int IDX_W  = ADDR_W - 3;
  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0] ram [RAM_WORDS];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             rd_is_ram;
  logic             rd_in_range;
  logic             ld_in_range;
  logic             rd_acc;
  logic             rd_err;
  logic [31:0]      rd_dat;

  logic [READ_LAT-1:0]       pipe_vld;
  logic [READ_LAT-1:0]       pipe_err;
  logic [READ_LAT-1:0][31:0] pipe_dat;

  logic unused_lsbs;
  assign unused_lsbs = ^{addr_i[1:0], ld_addr_i[1:0]};

  assign rd_is_ram   = addr_i[ADDR_W-1];
  assign rd_idx      = addr_i[ADDR_W-2:2];
  assign ld_idx      = ld_addr_i[ADDR_W-2:2];
  assign rd_in_range = 32'(rd_idx) < RAM_WORDS;
  assign ld_in_range = 32'(ld_idx) < RAM_WORDS;

  // Single-port RAM: a loader write owns the array this cycle.
  assign gnt_o    = rd_is_ram ? !ld_req_i : 1'b1;
  assign rd_acc   = req_i & gnt_o;
  assign ld_gnt_o = 1'b1;

`ifdef INSTR_MEM_ROM_EN
  logic [31:0] rom_dat;

  rom #(.AW(IDX_W)) u_rom (
    .addr_i  (rd_idx),
    .rdata_o (rom_dat)
  );
`endif

  always_comb begin
    rd_err = 1'b0;
    rd_dat = '0;
    if (rd_is_ram) begin
      if (rd_in_range) rd_dat = ram[rd_idx[RAM_AW-1:0]];
      else             rd_err = 1'b1;
    end else begin
`ifdef INSTR_MEM_ROM_EN
      rd_dat = rom_dat;
`else
      rd_err = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_req_i && ld_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (ld_be_i[k]) ram[ld_idx[RAM_AW-1:0]][8*k +: 8] <= ld_wdata_i[8*k +: 8];
      end
    end
  end

  // Payload only advances behind a valid bit, so the output holds the last response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      pipe_dat <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) begin
        pipe_err[0] <= rd_err;
        pipe_dat[0] <= rd_dat;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_err[i] <= pipe_err[i-1];
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign rvalid_o = pipe_vld[READ_LAT-1];
  assign err_o    = pipe_err[READ_LAT-1];
  assign rdata_o  = pipe_dat[READ_LAT-1];

endmodule

// File: tb/tb_instr_mem_pl.sv
// Bench for instr_mem_pl: four instances (READ_LAT 1..4) share one stimulus stream and a cycle-indexed reference model.
module tb_instr_mem_pl;
  localparam int AW = 14;
  localparam int NW = 1024;
  localparam int NI = 4;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ld_req = 1'b0;
  logic [AW-2:0] ld_addr = '0;
  logic [3:0]    be = '0;
  logic [31:0]   wdata = '0;

  logic        gnt    [NI];
  logic        rvalid [NI];
  logic        err    [NI];
  logic        ld_gnt [NI];
  logic [31:0] rdata  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instr_mem_pl #(.ADDR_W(AW), .RAM_WORDS(NW), .READ_LAT(g + 1)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .addr_i     (addr),
      .gnt_o      (gnt[g]),
      .rvalid_o   (rvalid[g]),
      .rdata_o    (rdata[g]),
      .err_o      (err[g]),
      .ld_req_i   (ld_req),
      .ld_addr_i  (ld_addr),
      .ld_be_i    (be),
      .ld_wdata_i (wdata),
      .ld_gnt_o   (ld_gnt[g])
    );
  end

  // Reference model: word array plus a per-cycle record of what was accepted.
  logic [31:0] mem   [NW];
  bit          h_vld [HN];
  bit          h_err [HN];
  logic [31:0] h_dat [HN];
  bit          held_err [NI];
  logic [31:0] held_dat [NI];
  int cyc = 0;
  int flush_before = 0;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_rd(input logic [AW-1:0] a, output bit e, output logic [31:0] d);
    int idx;
    idx = int'(a[AW-2:2]);
    e = 1'b1;
    d = '0;
    if (a[AW-1]) begin
      if (idx < NW) begin
        e = 1'b0;
        d = mem[idx];
      end
    end else begin
`ifdef INSTR_MEM_ROM_EN
      e = 1'b0;
      d = {16'hB007, idx[15:0]};
`endif
    end
  endfunction

  always @(posedge clk) begin
    bit          acc;
    bit          e;
    logic [31:0] d;
    int          li;
    acc = rst_n && req && (addr[AW-1] ? !ld_req : 1'b1);
    model_rd(addr, e, d);
    if (cyc < HN) begin
      h_vld[cyc] = acc;
      h_err[cyc] = e;
      h_dat[cyc] = d;
    end
    if (ld_req) begin
      li = int'(ld_addr[AW-2:2]);
      if (li < NW) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mem[li][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int c;
    bit ev;
    for (int g = 0; g < NI; g++) begin
      c  = cyc - (g + 1);
      ev = 1'b0;
      if (c >= 0 && c >= flush_before && c < HN) ev = h_vld[c];
      if (ev) begin
        held_err[g] = h_err[c];
        held_dat[g] = h_dat[c];
      end
      chk($sformatf("rvalid_L%0d", g + 1), 32'(rvalid[g]), 32'(ev));
      chk($sformatf("rdata_L%0d", g + 1), rdata[g], held_dat[g]);
      chk($sformatf("err_L%0d", g + 1), 32'(err[g]), 32'(held_err[g]));
      chk($sformatf("gnt_L%0d", g + 1), 32'(gnt[g]), 32'(addr[AW-1] ? !ld_req : 1'b1));
      chk($sformatf("ld_gnt_L%0d", g + 1), 32'(ld_gnt[g]), 32'd1);
    end
  end

  task automatic drive(input bit rq, input logic [AW-1:0] a, input bit lr,
                       input logic [AW-2:0] la, input logic [3:0] b, input logic [31:0] wd);
    req = rq; addr = a; ld_req = lr; ld_addr = la; be = b; wdata = wd;
    @(posedge clk);
    #1;
  endtask

  // Idles the bus and checks instance L on the L-th cycle after the grant.
  task automatic collect(input logic [31:0] exp_d, input bit exp_e, input string tag);
    req = 1'b0;
    ld_req = 1'b0;
    for (int j = 1; j <= NI; j++) begin
      @(negedge clk);
      chk($sformatf("%s_vld_L%0d", tag, j), 32'(rvalid[j-1]), 32'd1);
      chk($sformatf("%s_dat_L%0d", tag, j), rdata[j-1], exp_d);
      chk($sformatf("%s_err_L%0d", tag, j), 32'(err[j-1]), 32'(exp_e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_dir(input logic [AW-1:0] a, input logic [31:0] exp_d, input bit exp_e, input string tag);
    drive(1'b1, a, 1'b0, '0, '0, '0);
    collect(exp_d, exp_e, tag);
  endtask

  initial begin
    int cnt;
    logic [31:0] rom_exp;
    bit          rom_err;
    for (int g = 0; g < NI; g++) begin
      held_err[g] = 1'b0;
      held_dat[g] = '0;
    end
`ifdef INSTR_MEM_ROM_EN
    rom_exp = {16'hB007, 16'h0002};
    rom_err = 1'b0;
`else
    rom_exp = '0;
    rom_err = 1'b1;
`endif

    repeat (3) begin
      @(negedge clk);
      chk("rst_rvalid", 32'(rvalid[2]), 32'd0);
      chk("rst_rdata", rdata[2], 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NW; i++) drive(1'b0, '0, 1'b1, 13'(i * 4), 4'hF, $urandom);

    drive(1'b0, '0, 1'b1, 13'h0000, 4'hF, 32'hDEADBEEF);
    rd_dir(14'h2000, 32'hDEADBEEF, 1'b0, "rd_deadbeef");

    drive(1'b0, '0, 1'b1, 13'h0004, 4'hF, 32'h11223344);
    drive(1'b0, '0, 1'b1, 13'h0004, 4'b0101, 32'hAABBCCDD);
    rd_dir(14'h2004, 32'h11BB33DD, 1'b0, "rd_be0101");

    req = 1'b1; addr = 14'h2008;
    ld_req = 1'b1; ld_addr = 13'h0008; be = 4'hF; wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("gnt_conflict", 32'(gnt[0]), 32'd0);
    @(posedge clk);
    #1;
    rd_dir(14'h2008, 32'hCAFEF00D, 1'b0, "rd_retry");

    req = 1'b1; addr = 14'h0008;
    ld_req = 1'b1; ld_addr = 13'h000C; be = 4'hF; wdata = 32'h5A5AA5A5;
    @(negedge clk);
    chk("gnt_rom_with_ld", 32'(gnt[0]), 32'd1);
    @(posedge clk);
    #1;
    collect(rom_exp, rom_err, "rd_rom");
    rd_dir(14'h200C, 32'h5A5AA5A5, 1'b0, "rd_ld_beside_rom");

    rd_dir(14'h3000, 32'h0, 1'b1, "rd_oob");
    drive(1'b0, '0, 1'b1, 13'h1000, 4'hF, 32'hFFFFFFFF);
    for (int i = 0; i < NW; i++) drive(1'b1, {1'b1, 13'(i * 4)}, 1'b0, '0, '0, '0);
    repeat (5) drive(1'b0, '0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 8; i++)
      drive(1'b1, (i % 2 == 1) ? {1'b1, 13'(4 * (i / 2))} : 14'(4 * (i / 2)), 1'b0, '0, '0, '0);
    repeat (5) drive(1'b0, '0, 1'b0, '0, '0, '0);

    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0] a;
      logic [AW-2:0] la;
      a  = {1'($urandom_range(0, 1)), 11'($urandom_range(0, 1100)), 2'($urandom_range(0, 3))};
      la = {11'($urandom_range(0, 1100)), 2'($urandom_range(0, 3))};
      drive(1'($urandom_range(0, 1)), a, $urandom_range(0, 3) == 0, la, 4'($urandom), $urandom);
    end
    repeat (5) drive(1'b0, '0, 1'b0, '0, '0, '0);

    drive(1'b1, 14'h2000, 1'b0, '0, '0, '0);
    drive(1'b1, 14'h2004, 1'b0, '0, '0, '0);
    req = 1'b0;
    @(negedge clk);
    #1;
    flush_before = cyc;
    for (int g = 0; g < NI; g++) begin
      held_err[g] = 1'b0;
      held_dat[g] = '0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 32'(rvalid[3]), 32'd0);
    chk("rst_async_dat", rdata[3], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid[3]) cnt++;
    end
    chk("no_resp_after_rst", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
